seven_segment_scan_ctrl: RTL

SEVEN_SEGMENT_SCAN_CTRL -- requirements
Module: seven_segment_scan_ctrl

---
 rtl/seven_segment_scan_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/seven_segment_scan_ctrl.sv
// Multiplexed six-digit octal display scanner with a one-deep pending
// buffer. New values reach the display only on frame boundaries.
module seven_segment_scan_ctrl #(
  parameter int unsigned DIV = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] val_in,
  input  logic        val_valid,
  output logic        val_ready,
  input  logic        blank_lz,
  output logic [2:0]  dig_code,
  output logic [5:0]  dig_sel,
  output logic        frame_done
);

  localparam logic [15:0] LAST = 16'(DIV - 1);

  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] disp_q, disp_d;
  logic [15:0] pend_q, pend_d;
  logic        pflag_q, pflag_d;
  logic        fd_q, fd_d;

  logic        tick;
  logic        bnd;
  logic        accept;

  assign val_ready = rst_n && !pflag_q;
  assign accept    = val_valid && val_ready;
  assign tick      = (cnt_q == LAST);
  assign bnd       = tick && (idx_q == 3'd5);

  always_comb begin
    cnt_d   = tick ? 16'd0 : cnt_q + 16'd1;
    idx_d   = idx_q;
    disp_d  = disp_q;
    pend_d  = pend_q;
    pflag_d = pflag_q;
    fd_d    = bnd;
    if (tick) begin
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
    // accept needs pflag_q == 0, so it never collides with a transfer
    if (bnd && pflag_q) begin
      disp_d  = pend_q;
      pflag_d = 1'b0;
    end
    if (accept) begin
      pend_d  = val_in;
      pflag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      disp_q  <= '0;
      pend_q  <= '0;
      pflag_q <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      pflag_q <= pflag_d;
      fd_q    <= fd_d;
    end
  end

  assign frame_done = fd_q;

  logic [2:0] digit;
  logic [5:0] sel_raw;
  logic       lead;
  logic       blank;

  // lead: every bit from this digit upward is zero
  always_comb begin
    digit   = 3'd0;
    sel_raw = 6'd0;
    lead    = 1'b0;
    unique case (idx_q)
      3'd0: begin
        digit   = disp_q[2:0];
        sel_raw = 6'b000001;
      end
      3'd1: begin
        digit   = disp_q[5:3];
        sel_raw = 6'b000010;
        lead    = (disp_q[15:3] == 13'd0);
      end
      3'd2: begin
        digit   = disp_q[8:6];
        sel_raw = 6'b000100;
        lead    = (disp_q[15:6] == 10'd0);
      end
      3'd3: begin
        digit   = disp_q[11:9];
        sel_raw = 6'b001000;
        lead    = (disp_q[15:9] == 7'd0);
      end
      3'd4: begin
        digit   = disp_q[14:12];
        sel_raw = 6'b010000;
        lead    = (disp_q[15:12] == 4'd0);
      end
      3'd5: begin
        digit   = {2'b00, disp_q[15]};
        sel_raw = 6'b100000;
        lead    = !disp_q[15];
      end
      default: begin
        digit   = 3'd0;
        sel_raw = 6'd0;
        lead    = 1'b0;
      end
    endcase
  end

  assign blank    = blank_lz && lead;
  assign dig_sel  = blank ? 6'd0 : sel_raw;
  assign dig_code = blank ? 3'd0 : digit;

endmodule
